// File: rtl/axi_mem2p_pkg.sv
// Shared definitions for the two-port memory AXI read front end:
// burst and response encodings, AR length width and the read FSM states.
package axi_mem2p_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } rd_state_e;

  // Index width that stays legal for a single-entry structure.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/axi_mem2p_rfifo.sv
// Show-ahead synchronous FIFO with occupancy output; the head entry is
// presented on dout whenever the FIFO is not empty.
module axi_mem2p_rfifo
  import axi_mem2p_pkg::*;
#(
  parameter int unsigned G_WIDTH = 8,
  parameter int unsigned G_DEPTH = 4,
  parameter int unsigned G_CNTW  = $clog2(G_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [G_WIDTH-1:0] din,
  input  logic              pop,
  output logic [G_WIDTH-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [G_CNTW-1:0] count
);

  localparam int unsigned PTR_W = clog2_min1(G_DEPTH);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [G_CNTW-1:0]  count_q, count_d;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(G_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == G_CNTW'(G_DEPTH));
  assign count  = count_q;
  assign dout   = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + G_CNTW'(1);
      2'b01:   count_d = count_q - G_CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/axi_mem2p_rd.sv
// AXI4 read front end for port B of the dual-port block memory: issues one
// word read per credit, tracks the fixed memory latency and queues R beats.
module axi_mem2p_rd
  import axi_mem2p_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH     = 32,
  parameter int unsigned G_MEMDEPTH      = 1024,
  parameter int unsigned G_ADDRWIDTH     = $clog2(G_MEMDEPTH),
  parameter int unsigned G_AXI_ADDRWIDTH = 32,
  parameter int unsigned G_IDWIDTH       = 4,
  parameter int unsigned G_BUFFER        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [G_IDWIDTH-1:0]       s_axi_arid,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]       s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [G_IDWIDTH-1:0]       s_axi_rid,
  output logic [G_DATAWIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic                       enb,
  output logic [G_ADDRWIDTH-1:0]     addrb,
  input  logic [G_DATAWIDTH-1:0]     doutb
);

  localparam int unsigned PIPE_LEN   = 1 + G_BUFFER;
  localparam int unsigned FIFO_DEPTH = G_BUFFER + 3;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BYTE_SHIFT = $clog2(G_DATAWIDTH / 8);
  localparam int unsigned BEAT_W     = AXI_LEN_W + 1;
  localparam int unsigned ENTRY_W    = G_IDWIDTH + 1 + G_DATAWIDTH;

  rd_state_e            state_q, state_d;
  logic [G_IDWIDTH-1:0] id_q, id_d;
  logic [G_ADDRWIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]    beats_q, beats_d;
  logic                 fixed_q, fixed_d;

  logic [PIPE_LEN-1:0]  pipe_vld_q, pipe_vld_d;
  logic [PIPE_LEN-1:0]  pipe_last_q, pipe_last_d;
  logic [G_IDWIDTH-1:0] pipe_id_q [PIPE_LEN];
  logic [G_IDWIDTH-1:0] pipe_id_d [PIPE_LEN];

  logic                 ar_hs_c;
  logic                 ar_fixed_c;
  logic                 issue_c;
  logic                 last_c;
  logic                 has_credit_c;
  logic [CNT_W-1:0]     inflight_c;
  logic [CNT_W-1:0]     used_c;
  logic [G_ADDRWIDTH-1:0] addr_inc_c;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_din;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;

  logic                 unused_ok;

  // Transfer size is always full width; arsize and fifo_full carry no information here.
  assign unused_ok = ^{s_axi_arsize, fifo_full};

  assign s_axi_arready = (state_q == S_IDLE) && !rst;
  assign ar_hs_c       = s_axi_arvalid && s_axi_arready;

  // WRAP and reserved encodings behave as INCR.
  always_comb begin
    ar_fixed_c = 1'b0;
    case (s_axi_arburst)
      BURST_FIXED: ar_fixed_c = 1'b1;
      BURST_INCR:  ar_fixed_c = 1'b0;
      BURST_WRAP:  ar_fixed_c = 1'b0;
      default:     ar_fixed_c = 1'b0;
    endcase
  end

  // Credit: every issued read owns a FIFO slot from issue until it is popped.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < PIPE_LEN; i++) begin
      inflight_c = inflight_c + CNT_W'(pipe_vld_q[i]);
    end
    used_c       = fifo_count + inflight_c;
    has_credit_c = (used_c < CNT_W'(FIFO_DEPTH));
  end

  assign addr_inc_c = (addr_q == G_ADDRWIDTH'(G_MEMDEPTH - 1)) ? '0
                                                              : addr_q + G_ADDRWIDTH'(1);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    fixed_d = fixed_q;
    issue_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs_c) begin
          id_d    = s_axi_arid;
          addr_d  = G_ADDRWIDTH'(s_axi_araddr >> BYTE_SHIFT);
          beats_d = BEAT_W'(s_axi_arlen) + BEAT_W'(1);
          fixed_d = ar_fixed_c;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (has_credit_c) begin
          issue_c = 1'b1;
          last_c  = (beats_q == BEAT_W'(1));
          beats_d = beats_q - BEAT_W'(1);
          if (!fixed_q) begin
            addr_d = addr_inc_c;
          end
          if (last_c) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enb   = issue_c;
  assign addrb = addr_q;

  // Latency pipe: tags travel alongside the memory read until doutb is valid.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_last_d    = pipe_last_q;
    pipe_id_d      = pipe_id_q;
    pipe_vld_d[0]  = issue_c;
    pipe_last_d[0] = last_c;
    pipe_id_d[0]   = id_q;
    for (int unsigned i = 1; i < PIPE_LEN; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_id_d[i]   = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      fixed_q     <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int unsigned i = 0; i < PIPE_LEN; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      fixed_q     <= fixed_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      pipe_id_q   <= pipe_id_d;
    end
  end

  assign fifo_push = pipe_vld_q[PIPE_LEN-1];
  assign fifo_din  = {pipe_id_q[PIPE_LEN-1], pipe_last_q[PIPE_LEN-1], doutb};
  assign fifo_pop  = s_axi_rvalid && s_axi_rready;

  axi_mem2p_rfifo #(
    .G_WIDTH (ENTRY_W),
    .G_DEPTH (FIFO_DEPTH),
    .G_CNTW  (CNT_W)
  ) u_rfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Payload is forced to zero when nothing is queued so reset shows clean outputs.
  assign s_axi_rvalid = !fifo_empty;
  assign s_axi_rdata  = fifo_empty ? '0   : fifo_dout[G_DATAWIDTH-1:0];
  assign s_axi_rlast  = fifo_empty ? 1'b0 : fifo_dout[G_DATAWIDTH];
  assign s_axi_rid    = fifo_empty ? '0   : fifo_dout[G_DATAWIDTH+1 +: G_IDWIDTH];
  assign s_axi_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axi_mem2p_rd.sv
// Directed bench for axi_mem2p_rd with a two-cycle-latency port-B memory model.
module tb_axi_mem2p_rd;
  import axi_mem2p_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        enb;
  logic [9:0]  addrb;
  logic [31:0] doutb;

  axi_mem2p_rd #(
    .G_DATAWIDTH     (32),
    .G_MEMDEPTH      (1024),
    .G_ADDRWIDTH     (10),
    .G_AXI_ADDRWIDTH (32),
    .G_IDWIDTH       (4),
    .G_BUFFER        (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .enb           (enb),
    .addrb         (addrb),
    .doutb         (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(a));
  endfunction

  // Port-B memory: read register plus one output register stage.
  logic [31:0] mem [1024];
  logic [31:0] mem_s1;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = exp_word(i);
  end
  always @(posedge clk) begin
    if (enb) mem_s1 <= mem[addrb];
    doutb <= mem_s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: R handshakes, issued addresses, and credit bookkeeping.
  logic [31:0] rd_q   [$];
  logic [3:0]  rid_q  [$];
  logic        rlast_q[$];
  int          rcyc_q [$];
  logic [9:0]  iss_q  [$];
  int          icyc_q [$];
  int          outstanding = 0;
  int          credit_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (enb) begin
        iss_q.push_back(addrb);
        icyc_q.push_back(cyc);
        if (outstanding >= 4) credit_viol++;
        outstanding++;
      end
      if (s_axi_rvalid && s_axi_rready) begin
        rd_q.push_back(s_axi_rdata);
        rid_q.push_back(s_axi_rid);
        rlast_q.push_back(s_axi_rlast);
        rcyc_q.push_back(cyc);
        outstanding--;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int k;
    k = 0;
    while (!s_axi_arready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check("ar_wait", 64'(s_axi_arready), 64'(1));
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  // Run until n beats arrive after base; rready is high one cycle in div.
  task automatic wait_beats(input string tag, input int base, input int n, input int div);
    int k;
    k = 0;
    while ((rd_q.size() - base) < n && k < 500) begin
      s_axi_rready = (k % div == 0);
      tick();
      k++;
    end
    s_axi_rready = 1'b1;
    check({tag, "_count"}, 64'(rd_q.size() - base), 64'(n));
  endtask

  int base, ibase, vbase;
  logic [31:0] e5 [4];

  initial begin
    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b010;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tick(); tick();

    check("rst_arready", 64'(s_axi_arready), 64'(0));
    check("rst_rvalid",  64'(s_axi_rvalid),  64'(0));
    check("rst_rdata",   64'(s_axi_rdata),   64'(0));
    check("rst_enb",     64'(enb),           64'(0));
    check("rst_addrb",   64'(addrb),         64'(0));
    rst = 1'b0;
    #1;
    check("rel_arready", 64'(s_axi_arready), 64'(1));
    tick();

    // 1: single beat latency and content
    base = rd_q.size();
    s_axi_arid = 4'd3; s_axi_araddr = 32'h14; s_axi_arlen = 8'd0;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check("t1_enb",     64'(enb),           64'(1));
    check("t1_addrb",   64'(addrb),         64'(5));
    check("t1_arready", 64'(s_axi_arready), 64'(0));
    tick(); tick();
    check("t1_early",   64'(s_axi_rvalid),  64'(0));
    tick();
    check("t1_rvalid",  64'(s_axi_rvalid),  64'(1));
    check("t1_rdata",   64'(s_axi_rdata),   64'(32'hDEADBEEF));
    check("t1_rid",     64'(s_axi_rid),     64'(3));
    check("t1_rlast",   64'(s_axi_rlast),   64'(1));
    check("t1_rresp",   64'(s_axi_rresp),   64'(0));
    tick(); tick();
    check("t1_beats",   64'(rd_q.size() - base), 64'(1));

    // 2: 16-beat INCR, full throughput
    base = rd_q.size();
    send_ar(4'd4, 32'h0, 8'd15, BURST_INCR);
    wait_beats("t2", base, 16, 1);
    if (rd_q.size() - base >= 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("t2_data%0d", i), 64'(rd_q[base+i]), 64'(exp_word(i)));
        check($sformatf("t2_last%0d", i), 64'(rlast_q[base+i]), 64'(i == 15));
      end
      check("t2_span", 64'(rcyc_q[base+15] - rcyc_q[base]), 64'(15));
      check("t2_rid",  64'(rid_q[base+7]), 64'(4));
    end

    // 3: INCR len 7 under heavy backpressure
    base = rd_q.size();
    vbase = credit_viol;
    send_ar(4'd5, 32'h100, 8'd7, BURST_INCR);
    wait_beats("t3", base, 8, 3);
    if (rd_q.size() - base >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t3_data%0d", i), 64'(rd_q[base+i]), 64'(32'hA500_0040 + 32'(i)));
        check($sformatf("t3_last%0d", i), 64'(rlast_q[base+i]), 64'(i == 7));
      end
    end
    check("t3_credit", 64'(credit_viol - vbase), 64'(0));
    repeat (6) tick();
    check("t3_nodup", 64'(rd_q.size() - base), 64'(8));

    // 4: FIXED burst holds the address
    base = rd_q.size();
    ibase = iss_q.size();
    send_ar(4'd6, 32'h40, 8'd3, BURST_FIXED);
    wait_beats("t4", base, 4, 1);
    check("t4_issues", 64'(iss_q.size() - ibase), 64'(4));
    if (rd_q.size() - base >= 4 && iss_q.size() - ibase >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t4_addr%0d", i), 64'(iss_q[ibase+i]), 64'(16));
        check($sformatf("t4_data%0d", i), 64'(rd_q[base+i]), 64'(32'hA500_0010));
        check($sformatf("t4_rid%0d", i),  64'(rid_q[base+i]), 64'(6));
      end
    end

    // 5: INCR wraps at the top of memory
    e5[0] = 32'hA500_03FE; e5[1] = 32'hA500_03FF; e5[2] = 32'hA500_0000; e5[3] = 32'hA500_0001;
    base = rd_q.size();
    send_ar(4'd7, 32'hFF8, 8'd3, BURST_INCR);
    wait_beats("t5", base, 4, 1);
    if (rd_q.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t5_data%0d", i), 64'(rd_q[base+i]), 64'(e5[i]));
      end
      check("t5_last", 64'(rlast_q[base+3]), 64'(1));
    end

    // Back-to-back bursts leave exactly one idle issue cycle
    base = rd_q.size();
    ibase = iss_q.size();
    send_ar(4'd1, 32'h200, 8'd1, BURST_INCR);
    send_ar(4'd2, 32'h300, 8'd1, BURST_INCR);
    wait_beats("b2b", base, 4, 1);
    if (rd_q.size() - base >= 4 && iss_q.size() - ibase >= 4) begin
      check("b2b_gap",   64'(icyc_q[ibase+2] - icyc_q[ibase+1]), 64'(2));
      check("b2b_rid0",  64'(rid_q[base+1]), 64'(1));
      check("b2b_rid1",  64'(rid_q[base+2]), 64'(2));
      check("b2b_last0", 64'(rlast_q[base+1]), 64'(1));
      check("b2b_last1", 64'(rlast_q[base+2]), 64'(0));
      check("b2b_data",  64'(rd_q[base+2]), 64'(32'hA500_00C0));
    end

    // 6: reset in the middle of a burst
    base = rd_q.size();
    send_ar(4'd8, 32'h80, 8'd7, BURST_INCR);
    wait_beats("t6", base, 2, 1);
    if (rd_q.size() - base >= 2) begin
      check("t6_pre1", 64'(rd_q[base+1]), 64'(32'hA500_0021));
    end
    rst = 1'b1;
    #1;
    check("t6_rvalid",  64'(s_axi_rvalid),  64'(0));
    check("t6_rlast",   64'(s_axi_rlast),   64'(0));
    check("t6_rid",     64'(s_axi_rid),     64'(0));
    check("t6_rdata",   64'(s_axi_rdata),   64'(0));
    check("t6_enb",     64'(enb),           64'(0));
    check("t6_addrb",   64'(addrb),         64'(0));
    check("t6_arready", 64'(s_axi_arready), 64'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    check("t6_rel_arready", 64'(s_axi_arready), 64'(1));
    check("t6_rel_rvalid",  64'(s_axi_rvalid),  64'(0));
    base = rd_q.size();
    send_ar(4'd9, 32'h1C, 8'd0, BURST_INCR);
    wait_beats("t6_post", base, 1, 1);
    repeat (10) tick();
    check("t6_single", 64'(rd_q.size() - base), 64'(1));
    if (rd_q.size() - base >= 1) begin
      check("t6_data", 64'(rd_q[base]),    64'(32'hA500_0007));
      check("t6_rid2", 64'(rid_q[base]),   64'(9));
      check("t6_last", 64'(rlast_q[base]), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_mem2p_rd.md
# axi_mem2p_rd

AXI4 read-channel front end for the two-port block memory's read port (port B). Accepts AR bursts, issues one word read per cycle on `enb`/`addrb`, absorbs the memory's fixed read latency, and returns data on the R channel under `rready` backpressure via a small credit-controlled FIFO. It sits between the AXI slave interconnect and port B of the dual-port memory wrapper. The write side feeds port A independently.

## Interface
Parameters:
- `G_DATAWIDTH`, 32: data width; power of two, ≥ 8.
- `G_MEMDEPTH`, 1024: memory depth in words.
- `G_ADDRWIDTH`, `$clog2(G_MEMDEPTH)`: memory word-address width.
- `G_AXI_ADDRWIDTH`, 32: AXI byte-address width.
- `G_IDWIDTH`, 4: AXI ID width.
- `G_BUFFER`, 1: memory output register stages. Must match the memory instance. Read latency is `1+G_BUFFER`.

Ports:
- `clk` in 1: single clock. Drives this block and memory port B (`clkb`).
- `rst` in 1: reset, asynchronous, active-high.
- `s_axi_arid` in `G_IDWIDTH`; `s_axi_araddr` in `G_AXI_ADDRWIDTH`; `s_axi_arlen` in 8; `s_axi_arsize` in 3 (ignored); `s_axi_arburst` in 2; `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rid` out `G_IDWIDTH`; `s_axi_rdata` out `G_DATAWIDTH`; `s_axi_rresp` out 2; `s_axi_rlast` out 1; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `enb` out 1: memory read enable.
- `addrb` out `G_ADDRWIDTH`: memory word address.
- `doutb` in `G_DATAWIDTH`: memory read data. Valid `1+G_BUFFER` cycles after `enb`.

## Operation
- FSM states:
  - IDLE: `arready`=1. On the AR handshake, capture:
    - id;
    - word address = `araddr >> log2(G_DATAWIDTH/8)`, truncated to `G_ADDRWIDTH`;
    - beats = `arlen+1`;
    - burst type.
    Then go to BURST.
  - BURST: `arready`=0. Issue a read (`enb`=1) in every cycle where credit > 0. After the final issue, return to IDLE.
- Addressing:
  - INCR: address +1 per beat, wrapping modulo `G_MEMDEPTH`.
  - FIXED: address held for all beats.
  - WRAP and reserved encodings are handled as INCR.
  - `arsize` is ignored; every beat is full width.
  - Unaligned low address bits are dropped.
- Latency pipe: a shift register of length `1+G_BUFFER` carries valid, id and last for each issued read. On exit, `doutb` plus the tag is pushed into the FIFO.
- FIFO:
  - Show-ahead, depth `G_BUFFER+3`.
  - Credit = depth − (FIFO occupancy + reads in flight).
  - The FIFO can never overflow. Overflow is an assertion target.
- R channel:
  - `rvalid` = FIFO not empty. `rdata`, `rid` and `rlast` come from the FIFO head.
  - Pop on `rvalid && rready`.
  - `rresp` is constant OKAY (2'b00).
  - `rlast`=1 only on a burst's final beat.
- A new AR may be accepted while earlier beats are still in flight or queued. Ordering is preserved and IDs are carried per entry.
- Reset, including mid-burst:
  - FSM → IDLE; pipe and FIFO cleared; in-flight data discarded.
  - `arready`=0 while `rst` is high, 1 from the first cycle after release.
  - `rvalid`, `rlast`, `rid`, `rdata`, `rresp`, `enb` and `addrb` are all 0.

## Timing
- AR handshake at cycle T → first `enb` at T+1 → `doutb` valid at T+2+G_BUFFER → `rvalid` at T+3+G_BUFFER. With G_BUFFER=1 this is T+4.
- With `rready` held high: one beat per cycle, no bubbles within a burst.
- Back-to-back bursts: last issue at X, next AR accepted at X+1, next issue at X+2. This gives exactly one idle issue cycle.
- `rready` low with FIFO full: `enb` stays 0 until credit returns. The next read issues the cycle after a pop frees a credit.
- Simultaneous FIFO push and pop in the same cycle leaves occupancy unchanged.
- `rdata`, `rid` and `rlast` are stable while `rvalid && !rready`.

## Structure
- Shared package `axi_mem2p_pkg`:
  - burst-type constants (FIXED/INCR/WRAP);
  - resp constants (OKAY);
  - `arlen` width;
  - FSM state enum.
- One sub-module, `axi_mem2p_rfifo`: parameterised show-ahead sync FIFO (width, depth) with occupancy count output. The credit logic and latency pipe stay in the top module.

## Test plan
1. Preload word 5 = 0xDEADBEEF; AR addr 0x14, len 0, id 3 → single R beat at T+4: rdata 0xDEADBEEF, rid 3, rlast 1, rresp 0.
2. INCR len 15 at 0x0, `rready` high → 16 consecutive-cycle beats of mem[0..15]; rlast only on beat 16.
3. INCR len 7, `rready` high one cycle in three → eight beats in order with no loss or duplication; `enb`=0 whenever credit = 0; FIFO never overflows.
4. FIXED len 3 at 0x40 → four beats, all mem[16], addrb constant 16.
5. INCR len 3 at word 1022 (G_MEMDEPTH 1024) → mem[1022], mem[1023], mem[0], mem[1].
6. Assert `rst` after 2 of 8 beats delivered → outputs go to reset values immediately. After release, AR len 0 returns the correct single beat with no stale data.
